vga_timing_gen: RTL and testbench

- Generates 640x480@60 VGA raster timing from the 25.175 MHz pixel clock.
- Outputs: pixel position, display-enable, h/v sync and line/frame strobes.
- Sits directly downstream of the PLL / reset-synchroniser stage, inside the internal demo top.
- Its position and enable outputs drive the pixel-colour generator; its syncs go to the VGA pins.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 tb/tb_vga_timing_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA raster timing generator.
//   - 640x480@60 default porch/sync/visible values for both axes
//   - derived default totals and the position counter width
//   - sync polarity enumeration
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Position counters are this wide; an axis total may not exceed POS_RANGE.
    localparam int POS_W     = 10;
    localparam int POS_RANGE = 1 << POS_W;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis (horizontal or vertical): a position counter that
//   runs 0..TOTAL-1 and wraps, with registered active-region and sync
//   flags that always describe the position currently held in pos.
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-low reset (pos -> TOTAL-1)
//   inc    in   advance the position by one this cycle
//   pos    out  current position
//   wrap   out  pos is at TOTAL-1, so the next inc wraps it to 0
//   active out  pos < VISIBLE
//   sync   out  SYNC_POL while pos is inside the sync window, else ~SYNC_POL
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE  = H_VISIBLE_DEF,
    parameter int FRONT    = H_FRONT_DEF,
    parameter int SYNC     = H_SYNC_DEF,
    parameter int BACK     = H_BACK_DEF,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [POS_W-1:0] pos,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam int SYNC_FIRST = VISIBLE + FRONT;
    localparam int SYNC_LAST  = VISIBLE + FRONT + SYNC - 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(TOTAL - 1);

    logic [POS_W-1:0] r_pos;
    logic             r_active;
    logic             r_sync;
    logic [POS_W-1:0] w_pos_nxt;
    int               w_pos_nxt_i;

    assign wrap        = (r_pos == LAST_POS);
    assign w_pos_nxt   = wrap ? '0 : r_pos + 1'b1;
    assign w_pos_nxt_i = int'(w_pos_nxt);

    // Flags are computed from the position being loaded, so they line up
    // with pos in the same cycle rather than trailing it by one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pos    <= LAST_POS;
            r_active <= 1'b0;
            r_sync   <= ~SYNC_POL;
        end else if (inc) begin
            r_pos    <= w_pos_nxt;
            r_active <= (w_pos_nxt_i < VISIBLE);
            r_sync   <= (w_pos_nxt_i >= SYNC_FIRST && w_pos_nxt_i <= SYNC_LAST) ?
                        SYNC_POL : ~SYNC_POL;
        end
    end

    assign pos    = r_pos;
    assign active = r_active;
    assign sync   = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator (640x480@60 by default). Every output is a
//   register and describes the position held in hpos/vpos that cycle.
// Ports:
//   clk          in   pixel clock
//   reset        in   synchronous, active-low reset
//   ce           in   pixel-advance enable
//   hpos/vpos    out  current position (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   display_on   out  position lies in the visible area
//   h_sync       out  horizontal sync at SYNC_POL level while active
//   v_sync       out  vertical sync at SYNC_POL level while active
//   line_start   out  one-cycle strobe when an advance brings hpos to 0
//   frame_start  out  one-cycle strobe when an advance brings position to (0,0)
//   frame_count  out  frames started modulo 256 (only with VGA_TIMING_FRAME_CNT_EN)
// Build option: define VGA_TIMING_FRAME_CNT_EN to add the frame_count port.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit SYNC_POL  = SYNC_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             display_on,
    output logic             h_sync,
    output logic             v_sync,
    output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [7:0]       frame_count,
`endif
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [POS_W-1:0] H_LAST_VIS = POS_W'(H_VISIBLE - 1);
    localparam logic [POS_W-1:0] V_LAST_VIS = POS_W'(V_VISIBLE - 1);

    if (H_TOTAL > POS_RANGE || V_TOTAL > POS_RANGE) begin : g_total_too_large
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed the position counter range");
    end

    logic w_h_wrap, w_v_wrap, w_v_inc;
    logic w_h_active, w_v_active;
    logic w_h_act_nxt, w_v_act_nxt;
    logic r_display_on, r_line_start, r_frame_start;

    // The vertical axis steps in the same cycle the horizontal one wraps.
    assign w_v_inc = ce & w_h_wrap;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .SYNC_POL(SYNC_POL)
    ) u_h_axis (
        .clk   (clk),
        .reset (reset),
        .inc   (ce),
        .pos   (hpos),
        .wrap  (w_h_wrap),
        .active(w_h_active),
        .sync  (h_sync)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .SYNC_POL(SYNC_POL)
    ) u_v_axis (
        .clk   (clk),
        .reset (reset),
        .inc   (w_v_inc),
        .pos   (vpos),
        .wrap  (w_v_wrap),
        .active(w_v_active),
        .sync  (v_sync)
    );

    // Active flags each axis will hold after an advance: entering position 0
    // turns the axis on, leaving the last visible position turns it off.
    assign w_h_act_nxt = w_h_wrap | ((hpos != H_LAST_VIS) & w_h_active);
    assign w_v_act_nxt = w_h_wrap ? (w_v_wrap | ((vpos != V_LAST_VIS) & w_v_active))
                                  : w_v_active;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= ce & w_h_wrap;
            r_frame_start <= ce & w_h_wrap & w_v_wrap;
            if (ce) begin
                r_display_on <= w_h_act_nxt & w_v_act_nxt;
            end
        end
    end

    assign display_on  = r_display_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame_count <= 8'd0;
        end else if (ce & w_h_wrap & w_v_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two instances share clk/reset/ce: A uses the default 640x480 timing,
//   B uses a tiny active-high-sync raster (8x6) so whole frames are short.
//   A model tracks each instance as a linear index into its frame and
//   derives every output from that index with plain arithmetic.
module tb_vga_timing_gen;

    localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam int A_HT = 800, A_TOT = 800 * 525;
    localparam bit A_POL = 1'b0;

    localparam int B_HV = 4, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_HT = 8, B_TOT = 8 * 6;
    localparam bit B_POL = 1'b1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ce    = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos;
    logic a_disp, a_hs, a_vs, a_ls, a_fs;
    logic b_disp, b_hs, b_vs, b_ls, b_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] a_fc, b_fc;
`endif

    int errors = 0;
    int checks = 0;

    vga_timing_gen #(
        .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .SYNC_POL(A_POL)
    ) dut_a (
        .clk(clk), .reset(reset), .ce(ce),
        .hpos(a_hpos), .vpos(a_vpos), .display_on(a_disp),
        .h_sync(a_hs), .v_sync(a_vs), .line_start(a_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_count(a_fc),
`endif
        .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .SYNC_POL(B_POL)
    ) dut_b (
        .clk(clk), .reset(reset), .ce(ce),
        .hpos(b_hpos), .vpos(b_vpos), .display_on(b_disp),
        .h_sync(b_hs), .v_sync(b_vs), .line_start(b_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_count(b_fc),
`endif
        .frame_start(b_fs)
    );

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // p is the frame index (row-major); reset parks it on the last index.
    int         pa, pb;
    bit         adv;
    bit         mdl_valid = 1'b0;
    logic [7:0] fca, fcb;

    always @(posedge clk) begin
        if (!reset) begin
            mdl_valid <= 1'b1;
            pa        <= A_TOT - 1;
            pb        <= B_TOT - 1;
            adv       <= 1'b0;
            fca       <= 8'd0;
            fcb       <= 8'd0;
        end else if (ce) begin
            pa  <= (pa + 1) % A_TOT;
            pb  <= (pb + 1) % B_TOT;
            adv <= 1'b1;
            if (pa == A_TOT - 1) fca <= fca + 8'd1;
            if (pb == B_TOT - 1) fcb <= fcb + 8'd1;
        end else begin
            adv <= 1'b0;
        end
    end

    task automatic check_dut(input string tag, input int p, input bit a,
                             input int hv, input int hf, input int hs,
                             input int ht, input int vv, input int vf, input int vs,
                             input bit pol,
                             input logic [9:0] hpos, input logic [9:0] vpos,
                             input logic disp, input logic hsy, input logic vsy,
                             input logic ls, input logic fs);
        int h, v;
        bit e_disp, e_hs, e_vs, e_ls, e_fs;
        h      = p % ht;
        v      = p / ht;
        e_disp = (h < hv) && (v < vv);
        e_hs   = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
        e_vs   = (v >= vv + vf && v < vv + vf + vs) ? pol : ~pol;
        e_ls   = a && (h == 0);
        e_fs   = a && (p == 0);
        chk({tag, ".hpos"},        32'(hpos), 32'(h));
        chk({tag, ".vpos"},        32'(vpos), 32'(v));
        chk({tag, ".display_on"},  32'(disp), 32'(e_disp));
        chk({tag, ".h_sync"},      32'(hsy),  32'(e_hs));
        chk({tag, ".v_sync"},      32'(vsy),  32'(e_vs));
        chk({tag, ".line_start"},  32'(ls),   32'(e_ls));
        chk({tag, ".frame_start"}, 32'(fs),   32'(e_fs));
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mdl_valid) begin
            check_dut("A", pa, adv, A_HV, A_HF, A_HS, A_HT, A_VV, A_VF, A_VS, A_POL,
                      a_hpos, a_vpos, a_disp, a_hs, a_vs, a_ls, a_fs);
            check_dut("B", pb, adv, B_HV, B_HF, B_HS, B_HT, B_VV, B_VF, B_VS, B_POL,
                      b_hpos, b_vpos, b_disp, b_hs, b_vs, b_ls, b_fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("A.frame_count", 32'(a_fc), 32'(fca));
            chk("B.frame_count", 32'(b_fc), 32'(fcb));
`endif
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        int  n_disp, n_hs, n_ls, n_fs, n_vs, n_blank_disp;
        int  first_hs, last_disp, first_vs_h, first_vs_v, h0, nfs;
        bit  found;

        reset = 1'b0;
        ce    = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst.hpos",        32'(a_hpos), 32'd799);
        chk("rst.vpos",        32'(a_vpos), 32'd524);
        chk("rst.display_on",  32'(a_disp), 32'd0);
        chk("rst.h_sync",      32'(a_hs),   32'd1);
        chk("rst.v_sync",      32'(a_vs),   32'd1);
        chk("rst.line_start",  32'(a_ls),   32'd0);
        chk("rst.frame_start", 32'(a_fs),   32'd0);

        reset = 1'b1;
        @(negedge clk);
        chk("first.hpos",        32'(a_hpos), 32'd0);
        chk("first.vpos",        32'(a_vpos), 32'd0);
        chk("first.display_on",  32'(a_disp), 32'd1);
        chk("first.frame_start", 32'(a_fs),   32'd1);
        chk("first.line_start",  32'(a_ls),   32'd1);
        chk("first.h_sync",      32'(a_hs),   32'd1);
        chk("first.v_sync",      32'(a_vs),   32'd1);

        // One full line of A starting at hpos=0.
        n_disp = 0; n_hs = 0; n_ls = 0; first_hs = -1; last_disp = -1;
        for (int i = 0; i < A_HT; i++) begin
            if (a_disp === 1'b1) begin
                n_disp++;
                last_disp = int'(a_hpos);
            end
            if (a_hs === 1'b0) begin
                n_hs++;
                if (first_hs < 0) first_hs = int'(a_hpos);
            end
            if (a_ls === 1'b1) n_ls++;
            @(negedge clk);
        end
        chk("line.display_cycles",  32'(n_disp),    32'd640);
        chk("line.last_display_h",  32'(last_disp), 32'd639);
        chk("line.hsync_cycles",    32'(n_hs),      32'd96);
        chk("line.hsync_first_h",   32'(first_hs),  32'd656);
        chk("line.line_start_cnt",  32'(n_ls),      32'd1);
        chk("line.next_line_start", 32'(a_ls),      32'd1);
        chk("line.next_vpos",       32'(a_vpos),    32'd1);

        // One full frame of B starting at its frame_start.
        found = 1'b0;
        for (int i = 0; i < 2 * B_TOT && !found; i++) begin
            if (b_fs === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        chk("frame.found_start", 32'(found), 32'd1);
        n_disp = 0; n_vs = 0; n_ls = 0; n_fs = 0; n_blank_disp = 0;
        first_vs_h = -1; first_vs_v = -1;
        for (int i = 0; i < B_TOT; i++) begin
            if (b_disp === 1'b1) n_disp++;
            if (b_disp === 1'b1 && b_vpos >= 10'(B_VV)) n_blank_disp++;
            if (b_vs === 1'b1) begin
                n_vs++;
                if (first_vs_h < 0) begin
                    first_vs_h = int'(b_hpos);
                    first_vs_v = int'(b_vpos);
                end
            end
            if (b_ls === 1'b1) n_ls++;
            if (b_fs === 1'b1) n_fs++;
            @(negedge clk);
        end
        chk("frame.vsync_cycles",   32'(n_vs),         32'd8);
        chk("frame.vsync_first_h",  32'(first_vs_h),   32'd0);
        chk("frame.vsync_first_v",  32'(first_vs_v),   32'd4);
        chk("frame.display_cycles", 32'(n_disp),       32'd12);
        chk("frame.blank_display",  32'(n_blank_disp), 32'd0);
        chk("frame.line_starts",    32'(n_ls),         32'd6);
        chk("frame.frame_starts",   32'(n_fs),         32'd1);
        chk("frame.period_start",   32'(b_fs),         32'd1);

        // ce pattern 1,0,0,1.
        h0 = pa % A_HT;
        ce = 1'b0;
        @(negedge clk);
        chk("hold1.hpos",       32'(a_hpos), 32'(h0));
        chk("hold1.line_start", 32'(a_ls),   32'd0);
        @(negedge clk);
        chk("hold2.hpos",       32'(a_hpos), 32'(h0));
        ce = 1'b1;
        @(negedge clk);
        chk("resume.hpos",      32'(a_hpos), 32'((h0 + 1) % A_HT));

        // Mid-frame reset.
        reset = 1'b0;
        @(negedge clk);
        chk("midrst.A.hpos",        32'(a_hpos), 32'd799);
        chk("midrst.A.vpos",        32'(a_vpos), 32'd524);
        chk("midrst.A.display_on",  32'(a_disp), 32'd0);
        chk("midrst.A.h_sync",      32'(a_hs),   32'd1);
        chk("midrst.A.frame_start", 32'(a_fs),   32'd0);
        chk("midrst.B.hpos",        32'(b_hpos), 32'd7);
        chk("midrst.B.vpos",        32'(b_vpos), 32'd5);
        chk("midrst.B.h_sync",      32'(b_hs),   32'd0);
        chk("midrst.B.v_sync",      32'(b_vs),   32'd0);
        reset = 1'b1;

        // Random ce with occasional resets; the compare process checks it all.
        for (int i = 0; i < 3000; i++) begin
            ce    = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 599) != 0);
            @(negedge clk);
        end
        reset = 1'b1;
        ce    = 1'b1;

`ifdef VGA_TIMING_FRAME_CNT_EN
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        nfs = 0;
        for (int i = 0; i < 258 * B_TOT && nfs < 257; i++) begin
            @(negedge clk);
            if (b_fs === 1'b1) begin
                nfs++;
                if (nfs == 256) chk("fc.after_256", 32'(b_fc), 32'd0);
                if (nfs == 257) chk("fc.after_257", 32'(b_fc), 32'd1);
            end
        end
        chk("fc.frames_seen", 32'(nfs), 32'd257);
`else
        nfs = 0;
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
